// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR register bank.
// Mode encodings and the per-bit next-state rule.
package sr_bank_pkg;

  localparam logic [1:0] SR_SET_DOM = 2'd0;
  localparam logic [1:0] SR_RST_DOM = 2'd1;
  localparam logic [1:0] SR_TOGGLE  = 2'd2;
  localparam logic [1:0] SR_HOLD    = 2'd3;

  function automatic logic sr_next(
    input logic       q,
    input logic       s,
    input logic       r,
    input logic [1:0] mode
  );
    logic n;
    n = q;
    case ({s, r})
      2'b10: n = 1'b1;
      2'b01: n = 1'b0;
      2'b00: n = q;
      default: begin
        case (mode)
          SR_SET_DOM: n = 1'b1;
          SR_RST_DOM: n = 1'b0;
          SR_TOGGLE:  n = ~q;
          default:    n = q;
        endcase
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: state, complement and edge-event registers.
// Exports a combinational change flag for the bank counter.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int unsigned MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic load,
  input  logic d,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic chg
);

  localparam logic [1:0] MODE_SEL = MODE[1:0];

  logic q_d, q_q;
  logic qbar_q;
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = sr_next(q_q, s, r, MODE_SEL);
    end
    rise_d = ~q_q & q_d;
    fall_d = q_q & ~q_d;
  end

  // Qbar is its own flop but always loaded with the complement of Q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= rst_val;
      qbar_q <= ~rst_val;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = q_d ^ q_q;

endmodule

// File: rtl/sr_register_bank.sv
// Bank of WIDTH clocked SR cells with event pulses
// and a saturating count of edges on which any bit changed.
module sr_register_bank
  import sr_bank_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       MODE      = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             ChgCntClr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic [CNT_W-1:0] ChgCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] chg;
  logic             any_chg;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE(MODE)
    ) u_cell (
      .clk    (Clk),
      .rst    (Rst),
      .rst_val(RESET_VAL[i]),
      .en     (En),
      .s      (S[i]),
      .r      (R[i]),
      .load   (Load),
      .d      (D[i]),
      .q      (Q[i]),
      .qbar   (Qbar[i]),
      .rise   (Rise[i]),
      .fall   (Fall[i]),
      .chg    (chg[i])
    );
  end

  assign any_chg = |chg;

  // A clear that coincides with a change counts that change.
  always_comb begin
    cnt_d = cnt_q;
    if (ChgCntClr) begin
      cnt_d = any_chg ? CNT_ONE : '0;
    end else if (any_chg && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ChgCnt = cnt_q;

endmodule

// File: tb/tb_sr_register_bank.sv
// Bench for sr_register_bank: five instances (modes 0..3,
// plus a toggle bank with a 2-bit counter) on shared stimulus.
module tb_sr_register_bank;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst, en, load, clr;
  logic [3:0] s, r, d;

  logic [3:0] q_o  [N];
  logic [3:0] qb_o [N];
  logic [3:0] ri_o [N];
  logic [3:0] fa_o [N];
  logic [7:0] cnt_o[N];

  logic [3:0] m_q   [N];
  logic [3:0] m_rise[N];
  logic [3:0] m_fall[N];
  int         m_cnt [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CW = (g < 4) ? 8 : 2;
    localparam int MD = (g < 4) ? g : 2;
    logic [CW-1:0] cnt_w;
    sr_register_bank #(
      .WIDTH    (4),
      .MODE     (MD),
      .RESET_VAL(4'b1010),
      .CNT_W    (CW)
    ) u_dut (
      .Clk      (clk),
      .Rst      (rst),
      .En       (en),
      .S        (s),
      .R        (r),
      .Load     (load),
      .D        (d),
      .ChgCntClr(clr),
      .Q        (q_o[g]),
      .Qbar     (qb_o[g]),
      .Rise     (ri_o[g]),
      .Fall     (fa_o[g]),
      .ChgCnt   (cnt_w)
    );
    assign cnt_o[g] = 8'(cnt_w);
  end

  function automatic int mode_of(int i);
    return (i < 4) ? i : 2;
  endfunction

  function automatic int max_of(int i);
    return (i < 4) ? 255 : 3;
  endfunction

  // Reference: whole-vector boolean forms of each S=R=1 policy.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      logic [3:0] q;
      logic [3:0] nq;
      q = m_q[i];
      if (load) nq = d;
      else if (!en) nq = q;
      else begin
        case (mode_of(i))
          0:       nq = s | (q & ~r);
          1:       nq = ~r & (q | s);
          2:       nq = (s & ~q) | (~r & q);
          default: nq = (s & ~r) | (q & ~(s ^ r));
        endcase
      end
      if (rst) begin
        m_q[i] = 4'b1010;
        m_rise[i] = '0;
        m_fall[i] = '0;
        m_cnt[i] = 0;
      end else begin
        m_rise[i] = ~q & nq;
        m_fall[i] = q & ~nq;
        if (clr) m_cnt[i] = (nq != q) ? 1 : 0;
        else if (nq != q && m_cnt[i] < max_of(i)) m_cnt[i]++;
        m_q[i] = nq;
      end
    end
    #1;
  endtask

  task automatic drive(bit rs, bit e, logic [3:0] ss, logic [3:0] rr,
                       bit ld, logic [3:0] dd, bit cl);
    rst = rs; en = e; s = ss; r = rr; load = ld; d = dd; clr = cl;
  endtask

  task automatic test_reset();
    drive(1, 0, '0, '0, 0, '0, 0);
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (q_o[i] !== 4'b1010 || qb_o[i] !== 4'b0101 ||
          ri_o[i] !== 4'b0 || fa_o[i] !== 4'b0 || cnt_o[i] !== 8'd0) begin
        n_errors++;
        $display("FAIL reset dut%0d got q=%b qb=%b ri=%b fa=%b c=%0d want 1010 0101 0 0 0",
                 i, q_o[i], qb_o[i], ri_o[i], fa_o[i], cnt_o[i]);
      end
    end
    drive(0, 1, 4'b0001, '0, 0, '0, 0);
    tick();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (q_o[i] !== 4'b1011 || ri_o[i] !== 4'b0001 ||
          fa_o[i] !== 4'b0 || cnt_o[i] !== 8'd1) begin
        n_errors++;
        $display("FAIL first_set dut%0d got q=%b ri=%b fa=%b c=%0d want 1011 0001 0000 1",
                 i, q_o[i], ri_o[i], fa_o[i], cnt_o[i]);
      end
    end
  endtask

  task automatic test_both_set();
    logic [3:0] exp_q[N];
    exp_q = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    drive(0, 0, '0, '0, 1, 4'b0000, 0);
    tick();
    drive(0, 1, 4'b1111, 4'b1111, 0, '0, 0);
    tick();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (q_o[i] !== exp_q[i] || ri_o[i] !== exp_q[i] ||
          qb_o[i] !== ~exp_q[i]) begin
        n_errors++;
        $display("FAIL both_sr dut%0d got q=%b ri=%b qb=%b want q=ri=%b",
                 i, q_o[i], ri_o[i], qb_o[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_q[3];
    exp_q = '{4'b0011, 4'b0000, 4'b0011};
    drive(0, 0, '0, '0, 1, 4'b0000, 0);
    tick();
    drive(0, 0, '0, '0, 0, '0, 1);
    tick();
    drive(0, 1, 4'b0011, 4'b0011, 0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (q_o[2] !== exp_q[k] || ri_o[2] !== (exp_q[k] & 4'b0011) ||
          fa_o[2] !== (~exp_q[k] & 4'b0011)) begin
        n_errors++;
        $display("FAIL toggle step%0d got q=%b ri=%b fa=%b want q=%b",
                 k, q_o[2], ri_o[2], fa_o[2], exp_q[k]);
      end
    end
    n_checks++;
    if (cnt_o[2] !== 8'd3 || cnt_o[4] !== 8'd3) begin
      n_errors++;
      $display("FAIL toggle_cnt got %0d/%0d want 3/3", cnt_o[2], cnt_o[4]);
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 4'b1001, '0, 1, 4'b0110, 1);
    tick();
    drive(0, 1, 4'b1001, '0, 1, 4'b0110, 0);
    tick();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (q_o[i] !== 4'b0110 || ri_o[i] !== 4'b0 ||
          fa_o[i] !== 4'b0 || cnt_o[i] !== 8'd1) begin
        n_errors++;
        $display("FAIL load_prio dut%0d got q=%b ri=%b fa=%b c=%0d want 0110 0 0 1",
                 i, q_o[i], ri_o[i], fa_o[i], cnt_o[i]);
      end
    end
  endtask

  task automatic test_counter_sat();
    drive(0, 1, 4'b1111, 4'b1111, 0, '0, 0);
    for (int k = 0; k < 6; k++) tick();
    n_checks++;
    if (cnt_o[4] !== 8'd3 || cnt_o[2] !== 8'd7) begin
      n_errors++;
      $display("FAIL cnt_sat got %0d/%0d want 3/7", cnt_o[4], cnt_o[2]);
    end
    drive(0, 1, 4'b1111, 4'b1111, 0, '0, 1);
    tick();
    n_checks++;
    if (cnt_o[4] !== 8'd1 || cnt_o[2] !== 8'd1) begin
      n_errors++;
      $display("FAIL clr_with_chg got %0d/%0d want 1/1", cnt_o[4], cnt_o[2]);
    end
    drive(0, 0, 4'b1111, 4'b1111, 0, '0, 1);
    tick();
    n_checks++;
    if (cnt_o[4] !== 8'd0 || cnt_o[2] !== 8'd0) begin
      n_errors++;
      $display("FAIL clr_idle got %0d/%0d want 0/0", cnt_o[4], cnt_o[2]);
    end
  endtask

  task automatic test_enable_off();
    logic [3:0] held[N];
    held = m_q;
    drive(0, 0, 4'b1111, 4'b0000, 0, '0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (q_o[i] !== held[i] || ri_o[i] !== 4'b0 || fa_o[i] !== 4'b0) begin
          n_errors++;
          $display("FAIL en_off dut%0d got q=%b ri=%b fa=%b want q=%b",
                   i, q_o[i], ri_o[i], fa_o[i], held[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 4'b1111, 4'b1111, 0, '0, 0);
    tick();
    tick();
    drive(1, 1, 4'b1111, 4'b1111, 1, 4'b0101, 0);
    tick();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (q_o[i] !== 4'b1010 || ri_o[i] !== 4'b0 ||
          fa_o[i] !== 4'b0 || cnt_o[i] !== 8'd0) begin
        n_errors++;
        $display("FAIL rst_mid dut%0d got q=%b ri=%b fa=%b c=%0d want 1010 0 0 0",
                 i, q_o[i], ri_o[i], fa_o[i], cnt_o[i]);
      end
    end
    drive(0, 1, 4'b1111, 4'b1111, 0, '0, 0);
    tick();
    n_checks++;
    if (q_o[2] !== 4'b0101 || ri_o[2] !== 4'b0101 ||
        fa_o[2] !== 4'b1010 || cnt_o[2] !== 8'd1) begin
      n_errors++;
      $display("FAIL post_rst got q=%b ri=%b fa=%b c=%0d want 0101 0101 1010 1",
               q_o[2], ri_o[2], fa_o[2], cnt_o[2]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
            4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0,
            4'($urandom), $urandom_range(0, 15) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (q_o[i] !== m_q[i] || qb_o[i] !== ~m_q[i] ||
            ri_o[i] !== m_rise[i] || fa_o[i] !== m_fall[i] ||
            cnt_o[i] !== 8'(m_cnt[i])) begin
          n_errors++;
          $display("FAIL random c%0d dut%0d got q=%b qb=%b ri=%b fa=%b c=%0d want %b %b %b %b %0d",
                   k, i, q_o[i], qb_o[i], ri_o[i], fa_o[i], cnt_o[i],
                   m_q[i], ~m_q[i], m_rise[i], m_fall[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_q[i] = '0; m_rise[i] = '0; m_fall[i] = '0; m_cnt[i] = 0;
    end
    drive(1, 0, '0, '0, 0, '0, 0);
    @(negedge clk);
    test_reset();
    test_both_set();
    test_toggle();
    test_load_priority();
    test_counter_sat();
    test_enable_off();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_register_bank.md
Name: sr_register_bank

Overview:
- Parametrised successor to the single-bit SR flip-flop: a bank of WIDTH independent clocked SR storage cells.
- Adds:
  - synchronous active-high reset with a configurable reset pattern;
  - a selectable resolution mode for the S=R=1 case;
  - a global clock-enable and a parallel load;
  - per-bit registered rise/fall event pulses;
  - a saturating bank-change counter.
- Sits in the control/status path, where firmware-visible sticky flags and event indicators are collected.

Parameters:
- WIDTH, 8, number of SR channels (1..32).
- MODE, 0, S=R=1 resolution: 0 = set-dominant, 1 = reset-dominant, 2 = toggle (JK behaviour), 3 = hold.
- RESET_VAL, 0, WIDTH-bit value loaded into Q on reset.
- CNT_W, 8, width of the change counter (2..16).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous active-high reset.
- En  in  1  enables S/R evaluation; when low, S/R are ignored.
- S  in  WIDTH  per-channel set request.
- R  in  WIDTH  per-channel reset request.
- Load  in  1  parallel load strobe.
- D  in  WIDTH  parallel load data.
- ChgCntClr  in  1  clear for the change counter.
- Q  out  WIDTH  stored state.
- Qbar  out  WIDTH  always ~Q (registered alongside Q, never independently divergent).
- Rise  out  WIDTH  one-cycle pulse; bit i high in the cycle Q[i] has just gone 0->1.
- Fall  out  WIDTH  one-cycle pulse; bit i high in the cycle Q[i] has just gone 1->0.
- ChgCnt  out  CNT_W  number of clock edges on which any Q bit changed; saturating.

Behaviour:
- Reset: synchronous, active-high. Rst sampled high at a rising edge of Clk produces:
  - Q = RESET_VAL, Qbar = ~RESET_VAL;
  - Rise = 0, Fall = 0, ChgCnt = 0.
  - Reset-induced changes generate no Rise/Fall pulses and no count.
- Priority per edge, highest first: Rst > Load > En-qualified S/R > hold.
- Load=1: Qnext = D for all bits; S, R and En are ignored.
- En=1, Load=0, per bit i:
  - S=1, R=0 -> 1.
  - S=0, R=1 -> 0.
  - S=0, R=0 -> Q[i].
  - S=1, R=1 -> per MODE: 0 -> 1; 1 -> 0; 2 -> ~Q[i]; 3 -> Q[i].
- En=0, Load=0: Qnext = Q.
- Latency: one edge from a request to the Q update. Rise/Fall are registered in the same edge as Q:
  - Rise[i] <= ~Q[i] & Qnext[i];
  - Fall[i] <= Q[i] & ~Qnext[i].
- Pulses last exactly one cycle unless the bit changes again on the next edge.
  - Example: MODE 2 with S=R=1 held gives Rise and Fall alternating every cycle.
- Change counter, in priority order:
  - ChgCntClr=1 and no change on this edge -> 0.
  - ChgCntClr=1 and a change (Qnext != Q) on the same edge -> 1.
  - Otherwise a change increments ChgCnt by 1, saturating at 2^CNT_W-1.
  - A Load with D == Q is not a change.
- Reset mid-operation: any in-progress toggle, load or counter activity is discarded. The next edge with Rst low evaluates normally from RESET_VAL.
- Outputs are glitch-free registered values. No combinational path from inputs to outputs.

Decomposition:
- Shared package sr_bank_pkg:
  - mode constants SR_SET_DOM=0, SR_RST_DOM=1, SR_TOGGLE=2, SR_HOLD=3;
  - a function resolving the next state from (q, s, r, mode).
- Sub-module sr_cell:
  - one channel: Q, Qbar, Rise and Fall registers plus next-state logic;
  - reset bit passed in;
  - exports its Qnext != Q change flag.
- Top level:
  - generate loop of WIDTH sr_cell instances;
  - OR-reduction of the change flags;
  - the saturating counter.

Test Plan:
1. WIDTH=4, RESET_VAL=4'b1010, Rst=1 for 2 cycles -> Q=1010, Qbar=0101, Rise=Fall=0, ChgCnt=0. Then En=1, S=0001, R=0000 -> next cycle Q=1011, Rise=0001, ChgCnt=1.
2. MODE=0/1/3 from Q=0000, En=1, S=R=1111 for 1 cycle -> Q=1111 / 0000 / 0000 respectively. Rise=1111 only for MODE 0.
3. MODE=2 from Q=0000, S=R=0011 held 3 cycles -> Q=0011, 0000, 0011; Rise/Fall alternate; ChgCnt=3.
4. Load priority: Load=1, D=0110, En=1, S=1001 -> Q=0110. Next edge Load=1, D=0110 -> Rise=Fall=0, ChgCnt unchanged.
5. CNT_W=2, toggle every cycle for 6 cycles -> ChgCnt=3 (saturated). Then ChgCntClr=1 with a change on the same edge -> ChgCnt=1. Then ChgCntClr=1 without a change -> 0.
6. En=0 with S=1111 for 4 cycles -> Q unchanged, no pulses. Rst asserted mid-toggle burst -> Q=RESET_VAL on that edge, no Rise/Fall pulse.
